// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Brief    : Write-back sequencing stage for the SISC datapath. Holds ALU,
//             load and link values for the 3-input write-back mux, generates
//             the mux select and register-file write strobe/address, and
//             waits for variable-latency loads with a bounded timeout.
//  Options  : WB_FWD_EN - adds a registered forwarding port (fwd_valid,
//             fwd_addr, fwd_data) updated on every commit.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_start,
    input  logic [1:0]        wb_src,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] pc_link,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [DATA_W-1:0] mux_a,
    output logic [DATA_W-1:0] mux_b,
    output logic [DATA_W-1:0] mux_c,
    output logic [1:0]        mux_sel,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic              wb_busy,
    output logic              wb_done,
    output logic              wb_err
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    // Source encodings shared by wb_src and mux_sel
    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC  = 2'b10;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_MEM = 2'd1;
    localparam logic [1:0] COMMIT   = 2'd2;

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] cnt;

    // Next-cycle values of the registered outputs
    logic [CNT_W-1:0] cnt_nxt;
    logic             rf_we_nxt;
    logic             wb_err_nxt;
    logic             accept;
    logic             load_hit;
    logic             timed_out;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; starts are only honoured in IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (wb_start) begin
                    case (wb_src)
                        SRC_ALU, SRC_PC: next_state = COMMIT;
                        SRC_MEM:         next_state = WAIT_MEM;
                        default:         next_state = IDLE;
                    endcase
                end
            end
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    next_state = COMMIT;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE;
                end
            end
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output/control decode feeding the output registers
    always_comb begin
        accept     = (state == IDLE) && wb_start;
        load_hit   = (state == WAIT_MEM) && mem_rvalid;
        timed_out  = (state == WAIT_MEM) && !mem_rvalid && (cnt == CNT_LAST);
        rf_we_nxt  = (next_state == COMMIT);
        wb_err_nxt = wb_err | timed_out | (accept && (wb_src == 2'b11));
        cnt_nxt    = cnt;
        if (accept && (wb_src == SRC_MEM)) begin
            cnt_nxt = '0;
        end else if ((state == WAIT_MEM) && !mem_rvalid && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // Holding registers, strobes and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_a   <= '0;
            mux_b   <= '0;
            mux_c   <= '0;
            mux_sel <= SRC_ALU;
            rf_wa   <= '0;
            rf_we   <= 1'b0;
            wb_done <= 1'b0;
            wb_err  <= 1'b0;
            cnt     <= '0;
        end else begin
            rf_we   <= rf_we_nxt;
            wb_done <= rf_we_nxt;
            wb_err  <= wb_err_nxt;
            cnt     <= cnt_nxt;
            if (accept) begin
                rf_wa   <= wb_rd;
                mux_sel <= wb_src;
                mux_a   <= alu_res;
                mux_c   <= pc_link;
            end
            if (load_hit) begin
                mux_b <= mem_rdata;
            end
        end
    end

    assign wb_busy = (state != IDLE);

`ifdef WB_FWD_EN
    logic [DATA_W-1:0] fwd_sel_data;

    // Select the value being committed for the forwarding path
    always_comb begin
        case (mux_sel)
            SRC_MEM: fwd_sel_data = mux_b;
            SRC_PC:  fwd_sel_data = mux_c;
            default: fwd_sel_data = mux_a;
        endcase
    end

    // Forwarding registers, refreshed at the end of every commit cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else if (state == COMMIT) begin
            fwd_valid <= 1'b1;
            fwd_addr  <= rf_wa;
            fwd_data  <= fwd_sel_data;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Brief    : Directed self-checking bench for wb_stage. Forwarding checks
//             are compiled in when WB_FWD_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_start;
    logic [1:0]  wb_src;
    logic [3:0]  wb_rd;
    logic [15:0] alu_res;
    logic [15:0] pc_link;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [15:0] mux_a, mux_b, mux_c;
    logic [1:0]  mux_sel;
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic        wb_busy, wb_done, wb_err;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_addr;
    logic [15:0] fwd_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    wb_stage #(.DATA_W(16), .ADDR_W(4), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_start   (wb_start),
        .wb_src     (wb_src),
        .wb_rd      (wb_rd),
        .alu_res    (alu_res),
        .pc_link    (pc_link),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mux_a      (mux_a),
        .mux_b      (mux_b),
        .mux_c      (mux_c),
        .mux_sel    (mux_sel),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .wb_busy    (wb_busy),
        .wb_done    (wb_done),
        .wb_err     (wb_err)
`ifdef WB_FWD_EN
        ,
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [1:0] src, input logic [3:0] rd,
                               input logic [15:0] alu, input logic [15:0] pc);
        wb_start = 1'b1;
        wb_src   = src;
        wb_rd    = rd;
        alu_res  = alu;
        pc_link  = pc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wb_start = 1'b0; wb_src = 2'b00; wb_rd = 4'd0;
        alu_res = 16'h0; pc_link = 16'h0; mem_rdata = 16'h0; mem_rvalid = 1'b0;
        step; step;
        rst = 1'b0;
        n_checks++;
        if ({mux_a, mux_b, mux_c} !== 48'h0) begin
            n_fail++; $display("FAIL reset_mux: got %h/%h/%h want 0", mux_a, mux_b, mux_c);
        end
        n_checks++;
        if ({mux_sel, rf_wa, rf_we, wb_busy, wb_done, wb_err} !== 10'b0) begin
            n_fail++; $display("FAIL reset_ctrl: sel=%b wa=%0d we=%b busy=%b done=%b err=%b want all 0",
                               mux_sel, rf_wa, rf_we, wb_busy, wb_done, wb_err);
        end
`ifdef WB_FWD_EN
        n_checks++;
        if ({fwd_valid, fwd_addr, fwd_data} !== 21'h0) begin
            n_fail++; $display("FAIL reset_fwd: got %b/%0d/%h want 0", fwd_valid, fwd_addr, fwd_data);
        end
`endif
    endtask

    task automatic test_alu;
        drive_start(2'b00, 4'd3, 16'h1234, 16'h0101);
        step;
        wb_start = 1'b0;
        n_checks++;
        if ({rf_we, wb_done, wb_busy} !== 3'b111) begin
            n_fail++; $display("FAIL alu_commit: we/done/busy=%b want 111", {rf_we, wb_done, wb_busy});
        end
        n_checks++;
        if (rf_wa !== 4'd3 || mux_sel !== 2'b00 || mux_a !== 16'h1234 || mux_c !== 16'h0101) begin
            n_fail++; $display("FAIL alu_values: wa=%0d sel=%b a=%h c=%h want 3/00/1234/0101",
                               rf_wa, mux_sel, mux_a, mux_c);
        end
        step;
        n_checks++;
        if ({rf_we, wb_done, wb_busy} !== 3'b000) begin
            n_fail++; $display("FAIL alu_after: we/done/busy=%b want 000", {rf_we, wb_done, wb_busy});
        end
    endtask

    task automatic test_delayed_load;
        int busy_cnt = 0;
        int we_cnt = 0;
        drive_start(2'b01, 4'd5, 16'h0BAD, 16'h0C0C);
        step;                         // WAIT_MEM cycle 1
        wb_start = 1'b0;
        busy_cnt += int'(wb_busy); we_cnt += int'(rf_we);
        step;                         // cycle 2
        busy_cnt += int'(wb_busy); we_cnt += int'(rf_we);
        step;                         // cycle 3: rvalid driven here
        busy_cnt += int'(wb_busy); we_cnt += int'(rf_we);
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
        step;                         // COMMIT
        mem_rvalid = 1'b0; mem_rdata = 16'h0;
        busy_cnt += int'(wb_busy);
        n_checks++;
        if (we_cnt !== 0) begin
            n_fail++; $display("FAIL load_early_we: got %0d write strobes before data want 0", we_cnt);
        end
        n_checks++;
        if (rf_we !== 1'b1 || wb_done !== 1'b1 || mux_b !== 16'hBEEF || mux_sel !== 2'b01 || rf_wa !== 4'd5) begin
            n_fail++; $display("FAIL load_commit: we=%b done=%b b=%h sel=%b wa=%0d want 1/1/beef/01/5",
                               rf_we, wb_done, mux_b, mux_sel, rf_wa);
        end
        step;
        busy_cnt += int'(wb_busy);
        n_checks++;
        if (busy_cnt !== 4 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL load_busy: busy cycles=%0d we=%b want 4/0", busy_cnt, rf_we);
        end
        // rvalid in IDLE must not disturb mux_b
        mem_rvalid = 1'b1; mem_rdata = 16'h1111;
        step;
        mem_rvalid = 1'b0;
        n_checks++;
        if (mux_b !== 16'hBEEF || rf_we !== 1'b0 || wb_busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_rvalid: b=%h we=%b busy=%b want beef/0/0", mux_b, rf_we, wb_busy);
        end
    endtask

    task automatic test_timeout;
        int busy_cnt = 0;
        int we_cnt = 0;
        int guard = 0;
        drive_start(2'b01, 4'd7, 16'h0707, 16'h0808);
        step;
        wb_start = 1'b0;
        while (wb_busy === 1'b1 && guard < 40) begin
            busy_cnt++;
            we_cnt += int'(rf_we);
            n_checks++;
            if (wb_err !== 1'b0) begin
                n_fail++; $display("FAIL timeout_early_err: err=%b at wait cycle %0d want 0", wb_err, busy_cnt);
            end
            step;
            guard++;
        end
        n_checks++;
        if (busy_cnt !== 15 || we_cnt !== 0 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL timeout_len: wait cycles=%0d writes=%0d want 15/0", busy_cnt, we_cnt + int'(rf_we));
        end
        n_checks++;
        if (wb_err !== 1'b1 || wb_busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_err: err=%b busy=%b want 1/0", wb_err, wb_busy);
        end
        mem_rvalid = 1'b1; mem_rdata = 16'h2222;
        step;
        mem_rvalid = 1'b0;
        step;
        n_checks++;
        if (rf_we !== 1'b0 || mux_b !== 16'hBEEF || wb_busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_late_rvalid: we=%b b=%h busy=%b want 0/beef/0", rf_we, mux_b, wb_busy);
        end
    endtask

    task automatic test_illegal_overlap;
        rst = 1'b1; step; rst = 1'b0;
        n_checks++;
        if (wb_err !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: err=%b want 0", wb_err);
        end
        drive_start(2'b11, 4'd9, 16'h5555, 16'h6666);
        step;
        wb_start = 1'b0;
        n_checks++;
        if (wb_err !== 1'b1 || rf_we !== 1'b0 || wb_busy !== 1'b0) begin
            n_fail++; $display("FAIL illegal_src: err=%b we=%b busy=%b want 1/0/0", wb_err, rf_we, wb_busy);
        end
        step;
        n_checks++;
        if (rf_we !== 1'b0 || wb_err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_after: we=%b err=%b want 0/1", rf_we, wb_err);
        end
        // Load, then a competing ALU start during WAIT_MEM
        drive_start(2'b01, 4'd4, 16'hABCD, 16'h0444);
        step;
        drive_start(2'b00, 4'd1, 16'hFFFF, 16'hEEEE);
        step; step; step;
        n_checks++;
        if (mux_a !== 16'hABCD || rf_wa !== 4'd4 || mux_sel !== 2'b01 || mux_c !== 16'h0444
            || wb_busy !== 1'b1 || rf_we !== 1'b0) begin
            n_fail++; $display("FAIL overlap_ignored: a=%h wa=%0d sel=%b c=%h busy=%b we=%b want abcd/4/01/0444/1/0",
                               mux_a, rf_wa, mux_sel, mux_c, wb_busy, rf_we);
        end
        wb_start = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 16'h1357;
        step;                         // COMMIT
        mem_rvalid = 1'b0;
        drive_start(2'b00, 4'd1, 16'hFFFF, 16'hEEEE);
        n_checks++;
        if (rf_we !== 1'b1 || rf_wa !== 4'd4 || mux_b !== 16'h1357 || wb_err !== 1'b1) begin
            n_fail++; $display("FAIL overlap_commit: we=%b wa=%0d b=%h err=%b want 1/4/1357/1", rf_we, rf_wa, mux_b, wb_err);
        end
        step;                         // start during COMMIT must be dropped
        wb_start = 1'b0;
        n_checks++;
        if (wb_busy !== 1'b0 || rf_we !== 1'b0 || mux_a !== 16'hABCD || rf_wa !== 4'd4) begin
            n_fail++; $display("FAIL commit_start_ignored: busy=%b we=%b a=%h wa=%0d want 0/0/abcd/4",
                               wb_busy, rf_we, mux_a, rf_wa);
        end
        step;
        n_checks++;
        if (rf_we !== 1'b0 || wb_busy !== 1'b0) begin
            n_fail++; $display("FAIL commit_start_late: we=%b busy=%b want 0/0", rf_we, wb_busy);
        end
    endtask

    task automatic test_reset_mid_load;
        int we_cnt = 0;
        drive_start(2'b01, 4'd6, 16'h0606, 16'h0707);
        step;
        wb_start = 1'b0;
        step;
        rst = 1'b1;
        step;
        we_cnt += int'(rf_we);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 16'hAAAA;
        step;
        we_cnt += int'(rf_we);
        mem_rvalid = 1'b0;
        step;
        we_cnt += int'(rf_we);
        n_checks++;
        if ({mux_a, mux_b, mux_c} !== 48'h0 || {mux_sel, rf_wa, wb_busy, wb_done, wb_err} !== 9'b0 || we_cnt !== 0) begin
            n_fail++; $display("FAIL reset_mid_load: a=%h b=%h c=%h sel=%b wa=%0d busy=%b err=%b writes=%0d want all 0",
                               mux_a, mux_b, mux_c, mux_sel, rf_wa, wb_busy, wb_err, we_cnt);
        end
        drive_start(2'b10, 4'd15, 16'h7777, 16'h0042);
        step;
        wb_start = 1'b0;
        n_checks++;
        if (rf_we !== 1'b1 || wb_done !== 1'b1 || mux_c !== 16'h0042 || mux_sel !== 2'b10
            || rf_wa !== 4'd15 || mux_a !== 16'h7777 || mux_b !== 16'h0) begin
            n_fail++; $display("FAIL pc_commit: we=%b done=%b c=%h sel=%b wa=%0d a=%h b=%h want 1/1/0042/10/15/7777/0",
                               rf_we, wb_done, mux_c, mux_sel, rf_wa, mux_a, mux_b);
        end
        step;
        n_checks++;
        if (rf_we !== 1'b0 || wb_busy !== 1'b0) begin
            n_fail++; $display("FAIL pc_after: we=%b busy=%b want 0/0", rf_we, wb_busy);
        end
    endtask

`ifdef WB_FWD_EN
    task automatic test_forward;
        n_checks++;
        if (fwd_valid !== 1'b1 || fwd_addr !== 4'd15 || fwd_data !== 16'h0042) begin
            n_fail++; $display("FAIL fwd_pc: v=%b addr=%0d data=%h want 1/15/0042", fwd_valid, fwd_addr, fwd_data);
        end
        drive_start(2'b00, 4'd2, 16'h00FF, 16'h0999);
        step;
        wb_start = 1'b0;
        step;
        n_checks++;
        if (fwd_valid !== 1'b1 || fwd_addr !== 4'd2 || fwd_data !== 16'h00FF) begin
            n_fail++; $display("FAIL fwd_alu: v=%b addr=%0d data=%h want 1/2/00ff", fwd_valid, fwd_addr, fwd_data);
        end
        for (int i = 0; i < 5; i++) step;
        n_checks++;
        if (fwd_valid !== 1'b1 || fwd_addr !== 4'd2 || fwd_data !== 16'h00FF) begin
            n_fail++; $display("FAIL fwd_hold: v=%b addr=%0d data=%h want 1/2/00ff", fwd_valid, fwd_addr, fwd_data);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_alu;
        test_delayed_load;
        test_timeout;
        test_illegal_overlap;
        test_reset_mid_load;
`ifdef WB_FWD_EN
        test_forward;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
